// File: rtl/i2c_char_writer_pkg.sv
// Shared types and defaults for the I2C character-cell writer.
package i2c_char_writer_pkg;

   localparam int         TEXT_COLS_W    = 7;
   localparam int         TEXT_ROWS_W    = 6;
   localparam int         ATTR_BYTES_DEF = 3;
   localparam logic [6:0] I2C_CHAR_ADDR  = 7'h42;

   typedef enum logic [2:0] {
      I2CW_IDLE,
      I2CW_START,
      I2CW_BIT,
      I2CW_ACK,
      I2CW_STOP
   } i2cw_state_t;

   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

endpackage

// File: rtl/i2c_char_writer_quarter_timer.sv
// Quarter-bit timer: CLK_DIV-cycle counter stepping a 4-phase SCL sequence.
// I2C_WRITER_STRETCH_EN enables holding the count while a slave stretches SCL.
module i2c_quarter_timer
   import i2c_char_writer_pkg::*;
#(
   parameter int CLK_DIV = 125
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     clear,
   input  logic     run,
   input  logic     scl_oe,
   input  logic     scl_in,
   output quarter_t phase,
   output logic     tick,
   output logic     first
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          hold;

`ifdef I2C_WRITER_STRETCH_EN
   // SCL released by us but still low: the slave is stretching the bit
   assign hold = run && (phase == Q2 || phase == Q3) && !scl_oe && !scl_in;
`else
   logic unused_stretch;
   assign unused_stretch = scl_oe ^ scl_in;
   assign hold           = 1'b0;
`endif

   assign tick  = run && !hold && (cnt == LAST);
   assign first = run && !hold && (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt   <= '0;
         phase <= Q0;
      end else if (run) begin
         if (hold) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= quarter_t'(phase + 2'd1);
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_char_writer.sv
// I2C master writing one {column, row, attribute} cell as a single write transaction.
// Define I2C_WRITER_STRETCH_EN to honour slave clock stretching.
module i2c_char_writer
   import i2c_char_writer_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = I2C_CHAR_ADDR,
   parameter int         CLK_DIV    = 125,
   parameter int         ATTR_BYTES = ATTR_BYTES_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [TEXT_COLS_W-1:0]  xtext,
   input  logic [TEXT_ROWS_W-1:0]  ytext,
   input  logic [8*ATTR_BYTES-1:0] charattr,
   output logic                    busy,
   output logic                    done,
   output logic                    nack,
   output logic                    scl_oe,
   output logic                    sda_oe,
   input  logic                    sda_in,
   input  logic                    scl_in
);

   localparam int NBYTES = 3 + ATTR_BYTES;
   localparam int FW     = 8 * NBYTES;
   localparam int BCW    = $clog2(NBYTES);

   i2cw_state_t    state, state_nxt;
   quarter_t       phase;
   logic           tick, first, accept, seg_end, done_nxt, nack_flag;
   logic [FW-1:0]  frame;
   logic [2:0]     bit_cnt;
   logic [BCW-1:0] bytes_left;

   assign accept  = req_valid && req_ready;
   assign seg_end = tick && (phase == Q3);

   i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .run    (state != I2CW_IDLE),
      .scl_oe (scl_oe),
      .scl_in (scl_in),
      .phase  (phase),
      .tick   (tick),
      .first  (first)
   );

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      scl_oe    = 1'b0;
      sda_oe    = 1'b0;
      case (state)
         I2CW_IDLE:  if (accept) state_nxt = I2CW_START;
         I2CW_START: begin
            sda_oe = (phase == Q2) || (phase == Q3);
            scl_oe = (phase == Q3);
            if (seg_end) state_nxt = I2CW_BIT;
         end
         I2CW_BIT: begin
            scl_oe = (phase == Q0) || (phase == Q1);
            sda_oe = !frame[FW-1];
            if (seg_end && bit_cnt == 3'd0) state_nxt = I2CW_ACK;
         end
         I2CW_ACK: begin
            scl_oe = (phase == Q0) || (phase == Q1);
            if (seg_end) state_nxt = (nack_flag || bytes_left == '0) ? I2CW_STOP : I2CW_BIT;
         end
         I2CW_STOP: begin
            scl_oe = (phase == Q0);
            sda_oe = (phase != Q3);
            if (seg_end) begin
               state_nxt = I2CW_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = I2CW_IDLE;
      endcase
   end

   // Control: state, handshake and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= I2CW_IDLE;
         req_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         nack      <= 1'b0;
         nack_flag <= 1'b0;
      end else begin
         state     <= state_nxt;
         req_ready <= (state_nxt == I2CW_IDLE) && !done_nxt;
         busy      <= (state_nxt != I2CW_IDLE);
         done      <= done_nxt;
         nack      <= done_nxt && nack_flag;
         if (accept)
            nack_flag <= 1'b0;
         else if (state == I2CW_ACK && phase == Q3 && first)
            nack_flag <= nack_flag | sda_in;
      end
   end

   // Data: whole frame loaded at accept, shifted out MSB first
   always_ff @(posedge clk) begin
      if (accept) begin
         frame      <= {DEV_ADDR, 1'b0, 8'(xtext), 8'(ytext), charattr};
         bit_cnt    <= 3'd7;
         bytes_left <= BCW'(NBYTES - 1);
      end else if (seg_end) begin
         if (state == I2CW_BIT) begin
            frame   <= {frame[FW-2:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
         end else if (state == I2CW_ACK) begin
            bytes_left <= bytes_left - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2c_char_writer.sv
// Directed bench for i2c_char_writer with a byte-capturing, ACKing slave model.
module tb_i2c_char_writer;
   import i2c_char_writer_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   req_valid, req_ready, busy, done, nack;
   logic [TEXT_COLS_W-1:0] xtext;
   logic [TEXT_ROWS_W-1:0] ytext;
   logic [23:0]            charattr;
   logic                   scl_oe, sda_oe, sda_in, scl_in;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          dn_count = 0;
   int          nack_byte = 99;
   bit          stretch_arm = 1'b0;
   int          hold_cnt = 0;
   logic        ack_drive = 1'b0;
   logic [7:0]  got[$];
   int          rises = 0;

   always #5 clk = ~clk;

   i2c_char_writer #(.DEV_ADDR(7'h42), .CLK_DIV(4), .ATTR_BYTES(3)) dut (
      .clk       (clk),
      .reset     (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .xtext     (xtext),
      .ytext     (ytext),
      .charattr  (charattr),
      .busy      (busy),
      .done      (done),
      .nack      (nack),
      .scl_oe    (scl_oe),
      .sda_oe    (sda_oe),
      .sda_in    (sda_in),
      .scl_in    (scl_in)
   );

   assign sda_in = !(sda_oe || ack_drive);
   assign scl_in = !(scl_oe || hold_cnt != 0);

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (done) dn_count <= dn_count + 1;

   // Slave: frames bytes on SCL rises, ACKs every byte except nack_byte, optional stretch
   initial begin
      logic scl_lv, sda_lv, prev_scl, prev_sda, in_frame;
      logic [7:0] sh;
      int bp;
      prev_scl = 1'b1; prev_sda = 1'b1; in_frame = 1'b0; sh = '0;
      forever begin
         @(negedge clk);
         if (hold_cnt > 0) hold_cnt--;
         if (rst) begin
            in_frame = 1'b0; ack_drive = 1'b0; hold_cnt = 0;
            prev_scl = 1'b1; prev_sda = 1'b1;
         end else begin
            scl_lv = !scl_oe;
            sda_lv = !(sda_oe || ack_drive);
            if (scl_lv && prev_scl && prev_sda && !sda_lv) begin
               in_frame = 1'b1; rises = 0; got.delete();
            end else if (scl_lv && prev_scl && !prev_sda && sda_lv) begin
               in_frame = 1'b0;
            end
            if (in_frame && scl_lv && !prev_scl) begin
               rises++;
               bp = (rises - 1) % 9;
               if (bp < 8) sh = {sh[6:0], sda_lv};
               if (bp == 7) got.push_back(sh);
               if (stretch_arm && rises == 18) begin
                  hold_cnt = 10; stretch_arm = 1'b0;
               end
            end
            if (in_frame && !scl_lv && prev_scl && rises > 0) begin
               bp = (rises - 1) % 9;
               if (bp == 7) ack_drive = ((rises - 1) / 9 != nack_byte);
               else if (bp == 8) ack_drive = 1'b0;
            end
            prev_scl = scl_lv;
            prev_sda = sda_lv;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [6:0] x, input logic [5:0] y, input logic [23:0] a,
                       input bit keep, output int tacc);
      int n = 0;
      xtext = x; ytext = y; charattr = a; req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_accept", req_ready, 1);
      tacc = cyc + 1;
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("ready_after_accept", req_ready, 0);
   endtask

   task automatic wait_done(input int budget, output int dcyc, output logic dnack);
      int n = 0;
      dcyc = -1; dnack = 1'bx;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (done) begin
            dcyc = cyc; dnack = nack;
            break;
         end
      end
      chk("done_seen", done, 1);
   endtask

   task automatic check_frame(input logic [6:0] x, input logic [5:0] y, input logic [23:0] a);
      logic [47:0] exp;
      exp = {8'h84, 1'b0, x, 2'b00, y, a};
      chk("frame_len", got.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < got.size()) chk($sformatf("frame_byte%0d", i), got[i], exp[47-8*i -: 8]);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   tacc, dc, d0, exp_lat;
      logic dn;
      rst = 1'b1; req_valid = 1'b0; xtext = '0; ytext = '0; charattr = '0;

      // reset behaviour
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_scl_oe", scl_oe, 0);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_nack", nack, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_release", req_ready, 1);
      chk("busy_after_release", busy, 0);

      // full write with ACKing slave
      send(7'd5, 6'd3, 24'hA51C07, 1'b0, tacc);
      wait_done(2000, dc, dn);
      chk("latency_ack", dc - tacc, 896);
      chk("nack_clear", dn, 0);
      check_frame(7'd5, 6'd3, 24'hA51C07);
      chk("scl_rises_full", rises, 55);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 1);
      chk("done_one_cycle", done, 0);

      // address NACK
      nack_byte = 0;
      send(7'd12, 6'd7, 24'h00FF00, 1'b0, tacc);
      wait_done(2000, dc, dn);
      chk("latency_nack", dc - tacc, 176);
      chk("nack_with_done", dn, 1);
      chk("nack_bytes_sent", got.size(), 1);
      if (got.size() > 0) chk("nack_addr_byte", got[0], 8'h84);
      repeat (20) @(negedge clk);
      chk("nack_scl_rises", rises, 10);
      chk("nack_idle_scl", scl_oe, 0);
      nack_byte = 99;

      // back-to-back with req_valid held
      send(7'd1, 6'd2, 24'h010203, 1'b1, tacc);
      xtext = 7'h7E; ytext = 6'h3F; charattr = 24'hFFEE00;
      wait_done(2000, dc, dn);
      chk("latency_q1", dc - tacc, 896);
      check_frame(7'd1, 6'd2, 24'h010203);
      chk("q_done_scl", scl_oe, 0);
      chk("q_done_sda", sda_oe, 0);
      chk("q_done_ready", req_ready, 0);
      @(negedge clk);
      chk("q_gap_ready", req_ready, 1);
      chk("q_gap_scl", scl_oe, 0);
      chk("q_gap_sda", sda_oe, 0);
      tacc = cyc + 1;
      @(negedge clk);
      chk("q_second_busy", busy, 1);
      chk("q_accept_gap", tacc - dc, 2);
      req_valid = 1'b0;
      wait_done(2000, dc, dn);
      chk("latency_q2", dc - tacc, 896);
      check_frame(7'h7E, 6'h3F, 24'hFFEE00);
      @(negedge clk);

      // reset in the middle of the row byte
      send(7'd9, 6'd4, 24'h123456, 1'b0, tacc);
      repeat (350) @(negedge clk);
      rst = 1'b1;
      d0 = dn_count;
      @(negedge clk);
      chk("abort_scl", scl_oe, 0);
      chk("abort_sda", sda_oe, 0);
      chk("abort_busy", busy, 0);
      rst = 1'b0;
      repeat (1000) @(negedge clk);
      chk("abort_no_done", dn_count - d0, 0);
      send(7'h11, 6'h2A, 24'h00FF80, 1'b0, tacc);
      wait_done(2000, dc, dn);
      chk("latency_after_abort", dc - tacc, 896);
      chk("nack_after_abort", dn, 0);
      check_frame(7'h11, 6'h2A, 24'h00FF80);
      @(negedge clk);

      // slave stretches SCL 10 cycles at the column ACK
`ifdef I2C_WRITER_STRETCH_EN
      exp_lat = 906;
`else
      exp_lat = 896;
`endif
      stretch_arm = 1'b1;
      send(7'd5, 6'd3, 24'hA51C07, 1'b0, tacc);
      wait_done(2000, dc, dn);
      chk("latency_stretch", dc - tacc, exp_lat);
      chk("stretch_applied", stretch_arm, 0);
      chk("nack_stretch", dn, 0);
      check_frame(7'd5, 6'd3, 24'hA51C07);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
